// File: rtl/id_instr_buffer.sv
// rtl/id_instr_buffer.sv - IF->ID instruction buffer: small FIFO between fetch and decode
//
// Purpose:
//   Captures instr/PC pairs from the fetch stage into a DEPTH-entry circular
//   FIFO and presents the head entry, with RV64I fields sliced out, to the
//   decoder through a valid/ready handshake. An EX-stage flush drops all entries.
//
// Ports:
//   clk, rst                  clock; synchronous active-high reset
//   i_if_valid/i_if_instr/i_if_pc   fetch-side input
//   o_id_ready                back-pressure to IF (registered state only)
//   i_ex_flush                drop all buffered entries
//   i_dec_ready               decoder consumes head this cycle
//   o_id_valid/o_id_instr/o_id_pc   head entry (NOP / PC 0 while empty)
//   o_opcode .. o_funct7      combinational slices of o_id_instr
//   o_stall_cnt, o_flush_cnt  saturating counters (only with ID_BUF_STATS_EN)
//
// Configuration macro: ID_BUF_STATS_EN

module id_instr_buffer #(
    parameter int DEPTH = 2,
    parameter int XLEN  = 64,
    parameter int ILEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_if_valid,
    input  logic [ILEN-1:0]  i_if_instr,
    input  logic [XLEN-1:0]  i_if_pc,
    output logic             o_id_ready,
    input  logic             i_ex_flush,
    input  logic             i_dec_ready,
    output logic             o_id_valid,
    output logic [ILEN-1:0]  o_id_instr,
    output logic [XLEN-1:0]  o_id_pc,
`ifdef ID_BUF_STATS_EN
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt,
`endif
    output logic [6:0]       o_opcode,
    output logic [4:0]       o_rd,
    output logic [2:0]       o_funct3,
    output logic [4:0]       o_rs1,
    output logic [4:0]       o_rs2,
    output logic [6:0]       o_funct7
);

    localparam int PTR_W    = $clog2(DEPTH);
    localparam int CNT_BITS = PTR_W + 1;
    localparam logic [CNT_BITS-1:0] FULL_CNT = CNT_BITS'(DEPTH);
    localparam logic [ILEN-1:0]     NOP      = ILEN'(32'h0000_0013);

    // Field slicing assumes 32-bit instructions; pointer wrap assumes a power of 2.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || ILEN != 32 || CNT_W < 1) begin : g_bad_param
        $error("id_instr_buffer: unsupported parameter combination");
    end

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_PARTIAL,
        OCC_FULL
    } occ_e;

    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_BITS-1:0] count_q, count_d;
    occ_e                occ;
    logic                push, pop;

    logic [ILEN-1:0]     instr_mem [DEPTH];
    logic [XLEN-1:0]     pc_mem    [DEPTH];

    always_comb begin
        occ = OCC_PARTIAL;
        if (count_q == '0) begin
            occ = OCC_EMPTY;
        end else if (count_q == FULL_CNT) begin
            occ = OCC_FULL;
        end
    end

    // Handshake outputs depend only on registered occupancy, so IF and the
    // decoder never see a combinational loop through this block.
    assign o_id_ready = (occ != OCC_FULL);
    assign o_id_valid = (occ != OCC_EMPTY);

    assign push = i_if_valid & o_id_ready & ~i_ex_flush;
    assign pop  = o_id_valid & i_dec_ready & ~i_ex_flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_ex_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_BITS'(1);
                2'b01:   count_d = count_q - CNT_BITS'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Payload storage is qualified by count, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr_q] <= i_if_instr;
            pc_mem[wr_ptr_q]    <= i_if_pc;
        end
    end

    assign o_id_instr = o_id_valid ? instr_mem[rd_ptr_q] : NOP;
    assign o_id_pc    = o_id_valid ? pc_mem[rd_ptr_q]    : '0;

    assign o_opcode = o_id_instr[6:0];
    assign o_rd     = o_id_instr[11:7];
    assign o_funct3 = o_id_instr[14:12];
    assign o_rs1    = o_id_instr[19:15];
    assign o_rs2    = o_id_instr[24:20];
    assign o_funct7 = o_id_instr[31:25];

`ifdef ID_BUF_STATS_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (i_if_valid && !o_id_ready && stall_cnt_q != '1) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (i_ex_flush && flush_cnt_q != '1) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign o_stall_cnt = stall_cnt_q;
    assign o_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_instr_buffer.sv
// tb/tb_id_instr_buffer.sv - self-checking bench for id_instr_buffer

module tb_id_instr_buffer;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_if_valid = 1'b0;
    logic [31:0] i_if_instr = '0;
    logic [63:0] i_if_pc = '0;
    logic        o_id_ready;
    logic        i_ex_flush = 1'b0;
    logic        i_dec_ready = 1'b0;
    logic        o_id_valid;
    logic [31:0] o_id_instr;
    logic [63:0] o_id_pc;
    logic [6:0]  o_opcode;
    logic [4:0]  o_rd;
    logic [2:0]  o_funct3;
    logic [4:0]  o_rs1;
    logic [4:0]  o_rs2;
    logic [6:0]  o_funct7;
`ifdef ID_BUF_STATS_EN
    logic [31:0] o_stall_cnt;
    logic [31:0] o_flush_cnt;
`endif

    id_instr_buffer #(.DEPTH(DEPTH), .XLEN(64), .ILEN(32), .CNT_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_if_valid  (i_if_valid),
        .i_if_instr  (i_if_instr),
        .i_if_pc     (i_if_pc),
        .o_id_ready  (o_id_ready),
        .i_ex_flush  (i_ex_flush),
        .i_dec_ready (i_dec_ready),
        .o_id_valid  (o_id_valid),
        .o_id_instr  (o_id_instr),
        .o_id_pc     (o_id_pc),
`ifdef ID_BUF_STATS_EN
        .o_stall_cnt (o_stall_cnt),
        .o_flush_cnt (o_flush_cnt),
`endif
        .o_opcode    (o_opcode),
        .o_rd        (o_rd),
        .o_funct3    (o_funct3),
        .o_rs1       (o_rs1),
        .o_rs2       (o_rs2),
        .o_funct7    (o_funct7)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
    } ent_t;

    ent_t mq[$];
    int   m_stall = 0;
    int   m_flush = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    // One clock of stimulus; the reference model advances from the buffer's
    // rules applied to its own queue occupancy before the edge.
    task automatic cycle(input logic v, input logic [31:0] ins, input logic [63:0] pc,
                         input logic dr, input logic fl, input logic r);
        ent_t e;
        bit   can_push, can_pop, stall;
        i_if_valid  = v;
        i_if_instr  = ins;
        i_if_pc     = pc;
        i_dec_ready = dr;
        i_ex_flush  = fl;
        rst         = r;
        can_pop  = (mq.size() != 0) && dr;
        can_push = v && (mq.size() != DEPTH);
        stall    = v && (mq.size() == DEPTH);
        @(posedge clk);
        if (r) begin
            mq.delete();
            m_stall = 0;
            m_flush = 0;
        end else begin
            if (stall) m_stall++;
            if (fl) begin
                m_flush++;
                mq.delete();
            end else begin
                if (can_pop) void'(mq.pop_front());
                if (can_push) begin
                    e.instr = ins;
                    e.pc    = pc;
                    mq.push_back(e);
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        cycle(0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 1);
        n_cmp++; if (o_id_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %0b want 0", o_id_valid); end
        n_cmp++; if (o_id_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %0b want 1", o_id_ready); end
        n_cmp++; if (o_id_instr !== 32'h0000_0013) begin n_err++; $display("FAIL reset_instr got %h want 00000013", o_id_instr); end
        n_cmp++; if (o_id_pc !== 64'h0) begin n_err++; $display("FAIL reset_pc got %h want 0", o_id_pc); end
        n_cmp++; if ({o_opcode, o_rd, o_funct3, o_rs1, o_rs2, o_funct7} !== {7'h13, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0})
            begin n_err++; $display("FAIL reset_fields got op=%h rd=%0d f3=%0d rs1=%0d rs2=%0d f7=%h want NOP decode",
                                    o_opcode, o_rd, o_funct3, o_rs1, o_rs2, o_funct7); end
`ifdef ID_BUF_STATS_EN
        n_cmp++; if (o_stall_cnt !== 32'd0 || o_flush_cnt !== 32'd0)
            begin n_err++; $display("FAIL reset_stats got %0d/%0d want 0/0", o_stall_cnt, o_flush_cnt); end
`endif
        cycle(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_fill();
        cycle(1, 32'h00500093, 64'h0, 0, 0, 0);
        n_cmp++; if (o_id_valid !== 1'b1 || o_id_pc !== 64'h0) begin n_err++; $display("FAIL fill_first got v=%0b pc=%h want v=1 pc=0", o_id_valid, o_id_pc); end
        n_cmp++; if ({o_opcode, o_rd, o_rs1, o_rs2} !== {7'h13, 5'd1, 5'd0, 5'd5})
            begin n_err++; $display("FAIL fill_fields got op=%h rd=%0d rs1=%0d rs2=%0d want 13/1/0/5", o_opcode, o_rd, o_rs1, o_rs2); end
        cycle(1, 32'h00a00113, 64'h4, 0, 0, 0);
        n_cmp++; if (o_id_ready !== 1'b0) begin n_err++; $display("FAIL fill_full_ready got %0b want 0", o_id_ready); end
        n_cmp++; if (o_id_pc !== 64'h0) begin n_err++; $display("FAIL fill_head_pc got %h want 0", o_id_pc); end
        for (int k = 0; k < 2; k++) begin
            cycle(1, 32'h00f00193, 64'h8, 0, 0, 0);
            n_cmp++; if (o_id_ready !== 1'b0 || o_id_pc !== 64'h0)
                begin n_err++; $display("FAIL fill_hold got rdy=%0b pc=%h want rdy=0 pc=0", o_id_ready, o_id_pc); end
        end
        // Pop while full: the presented instruction is still refused this cycle.
        cycle(1, 32'h00f00193, 64'h8, 1, 0, 0);
        n_cmp++; if (o_id_ready !== 1'b1 || o_id_pc !== 64'h4 || o_id_instr !== 32'h00a00113)
            begin n_err++; $display("FAIL fill_pop_full got rdy=%0b pc=%h ins=%h want rdy=1 pc=4 ins=00a00113", o_id_ready, o_id_pc, o_id_instr); end
        cycle(1, 32'h00f00193, 64'h8, 0, 0, 0);
        n_cmp++; if (o_id_ready !== 1'b0) begin n_err++; $display("FAIL fill_third_accept got rdy=%0b want 0", o_id_ready); end
        cycle(0, 0, 0, 1, 0, 0);
        n_cmp++; if (o_id_pc !== 64'h8 || o_id_instr !== 32'h00f00193)
            begin n_err++; $display("FAIL fill_third_head got pc=%h ins=%h want pc=8 ins=00f00193", o_id_pc, o_id_instr); end
        cycle(0, 0, 0, 1, 0, 0);
        n_cmp++; if (o_id_valid !== 1'b0) begin n_err++; $display("FAIL fill_drained got v=%0b want 0", o_id_valid); end
    endtask

    task automatic test_stream();
        logic [31:0] ins [8];
        for (int k = 0; k < 8; k++) begin
            ins[k] = $urandom;
            cycle(1, ins[k], 64'(4 * k), 1, 0, 0);
            n_cmp++; if (o_id_valid !== 1'b1 || o_id_pc !== 64'(4 * k) || o_id_instr !== ins[k])
                begin n_err++; $display("FAIL stream_%0d got v=%0b pc=%h ins=%h want v=1 pc=%h ins=%h",
                                        k, o_id_valid, o_id_pc, o_id_instr, 64'(4 * k), ins[k]); end
        end
        cycle(0, 0, 0, 1, 0, 0);
        n_cmp++; if (o_id_valid !== 1'b0) begin n_err++; $display("FAIL stream_drain got v=%0b want 0", o_id_valid); end
    endtask

    task automatic test_flush();
        cycle(1, 32'h11111111, 64'h10, 0, 0, 0);
        cycle(1, 32'h22222222, 64'h14, 0, 0, 0);
        cycle(1, 32'h33333333, 64'h100, 0, 1, 0);
        n_cmp++; if (o_id_valid !== 1'b0 || o_id_ready !== 1'b1 || o_id_pc !== 64'h0)
            begin n_err++; $display("FAIL flush_state got v=%0b rdy=%0b pc=%h want v=0 rdy=1 pc=0", o_id_valid, o_id_ready, o_id_pc); end
        cycle(0, 0, 0, 0, 0, 0);
        n_cmp++; if (o_id_valid !== 1'b0) begin n_err++; $display("FAIL flush_dropped got v=%0b want 0", o_id_valid); end
        cycle(1, 32'h44444444, 64'h200, 0, 0, 0);
        n_cmp++; if (o_id_valid !== 1'b1 || o_id_pc !== 64'h200 || o_id_instr !== 32'h44444444)
            begin n_err++; $display("FAIL flush_after got v=%0b pc=%h ins=%h want v=1 pc=200 ins=44444444", o_id_valid, o_id_pc, o_id_instr); end
        cycle(0, 0, 0, 1, 0, 0);
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 5; i++) begin
            cycle(1, 32'h00000013 | (32'(i) << 7), 64'(4 * i), 0, 0, 0);
            n_cmp++; if (o_id_valid !== 1'b1 || o_id_pc !== 64'(4 * i) || o_rd !== 5'(i))
                begin n_err++; $display("FAIL wrap_%0d got v=%0b pc=%h rd=%0d want v=1 pc=%h rd=%0d",
                                        i, o_id_valid, o_id_pc, o_rd, 64'(4 * i), i); end
            cycle(0, 0, 0, 1, 0, 0);
            n_cmp++; if (o_id_valid !== 1'b0) begin n_err++; $display("FAIL wrap_pop_%0d got v=%0b want 0", i, o_id_valid); end
        end
    endtask

`ifdef ID_BUF_STATS_EN
    task automatic test_stats();
        cycle(0, 0, 0, 0, 0, 1);
        cycle(1, 32'h00500093, 64'h0, 0, 0, 0);
        cycle(1, 32'h00a00113, 64'h4, 0, 0, 0);
        for (int k = 0; k < 3; k++) cycle(1, 32'h00f00193, 64'h8, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 0);
        n_cmp++; if (o_stall_cnt !== 32'd3) begin n_err++; $display("FAIL stats_stall got %0d want 3", o_stall_cnt); end
        n_cmp++; if (o_flush_cnt !== 32'd1) begin n_err++; $display("FAIL stats_flush got %0d want 1", o_flush_cnt); end
        cycle(0, 0, 0, 0, 1, 0);
        n_cmp++; if (o_flush_cnt !== 32'd2) begin n_err++; $display("FAIL stats_flush_empty got %0d want 2", o_flush_cnt); end
    endtask
`endif

    task automatic test_random();
        logic [31:0] ei;
        logic [63:0] ep;
        for (int c = 0; c < 400; c++) begin
            cycle(($urandom % 4) != 0, $urandom, {$urandom, $urandom}, ($urandom % 3) != 0,
                  ($urandom % 16) == 0, ($urandom % 64) == 0);
            ei = (mq.size() != 0) ? mq[0].instr : 32'h0000_0013;
            ep = (mq.size() != 0) ? mq[0].pc : 64'h0;
            n_cmp++; if (o_id_valid !== (mq.size() != 0) || o_id_ready !== (mq.size() != DEPTH))
                begin n_err++; $display("FAIL rand_hs_%0d got v=%0b rdy=%0b want v=%0b rdy=%0b",
                                        c, o_id_valid, o_id_ready, mq.size() != 0, mq.size() != DEPTH); end
            n_cmp++; if (o_id_instr !== ei || o_id_pc !== ep)
                begin n_err++; $display("FAIL rand_head_%0d got ins=%h pc=%h want ins=%h pc=%h", c, o_id_instr, o_id_pc, ei, ep); end
            n_cmp++; if ({o_funct7, o_rs2, o_rs1, o_funct3, o_rd, o_opcode} !== ei)
                begin n_err++; $display("FAIL rand_fields_%0d got %h want %h", c,
                                        {o_funct7, o_rs2, o_rs1, o_funct3, o_rd, o_opcode}, ei); end
`ifdef ID_BUF_STATS_EN
            n_cmp++; if (o_stall_cnt !== 32'(m_stall) || o_flush_cnt !== 32'(m_flush))
                begin n_err++; $display("FAIL rand_stats_%0d got %0d/%0d want %0d/%0d", c, o_stall_cnt, o_flush_cnt, m_stall, m_flush); end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_stream();
        test_flush();
        test_wrap();
`ifdef ID_BUF_STATS_EN
        test_stats();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
